blur_scheduler: RTL and testbench

- Sequences the single blur engine through a chain of passes that builds one octave of the Gaussian scale stack: scale k+1 = blur(scale k), for k = 0..NUM_SCALES-2.
- Sits between the host/top FSM, the blur engine and the NUM_SCALES image banks.
- Selects the source and destination banks for each pass and arbitrates the shared bank read port between the engine and host readout.
- Runs a per-pass watchdog that flags a hung engine.

---
 rtl/blur_scheduler_pkg.sv | 15 +
 rtl/blur_scheduler_pass_watchdog.sv | 37 +++
 rtl/blur_scheduler.sv | 164 ++++++++++++++++
 tb/tb_blur_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blur_scheduler_pkg.sv
// Shared types and constants for the blur pass scheduler.
package blur_sched_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      WAIT   = 3'd2,
      DONE   = 3'd3,
      ERROR  = 3'd4
   } state_e;

   // Cycles from bank read enable to data on the bank data bus.
   localparam int BRAM_RD_LATENCY = 2;

endpackage

// File: rtl/blur_scheduler_pass_watchdog.sv
// Per-pass watchdog: saturating cycle counter with an expiry flag.
module pass_watchdog #(
   parameter int TIMEOUT = 65536
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

   // Saturate so a stalled enable can never wrap back under the limit.
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

   // Expiry fires in the cycle the count would step onto TIMEOUT-1, so the
   // caller leaves its wait state exactly TIMEOUT cycles after the clear.
   assign expired_o = en_i && (cnt_inc >= LIMIT);

   // Next count: clear wins over enable.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)     cnt_d = '0;
      else if (en_i) cnt_d = cnt_inc;
   end

   // Counter register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/blur_scheduler.sv
// Octave pass sequencer for the blur engine: bank selection, shared read
// port arbitration between engine and host, and a hung-engine watchdog.
module blur_scheduler
   import blur_sched_pkg::*;
#(
   parameter int BIT_DEPTH  = 8,
   parameter int WIDTH      = 64,
   parameter int HEIGHT     = 64,
   parameter int NUM_SCALES = 5,
   parameter int TIMEOUT    = 65536,
   localparam int AW = $clog2(WIDTH * HEIGHT),
   localparam int BW = $clog2(NUM_SCALES)
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          start_in,
   input  logic          clear_err_in,
   output logic          done_out,
   output logic          busy_out,
   output logic          error_out,
   output logic [BW-1:0] pass_idx_out,
   output logic          blur_start_out,
   input  logic          blur_done_in,
   input  logic [AW-1:0] eng_rd_addr_in,
   input  logic          eng_rd_valid_in,
   input  logic          host_rd_req_in,
   input  logic [BW-1:0] host_rd_bank_in,
   input  logic [AW-1:0] host_rd_addr_in,
   output logic          host_rd_grant_out,
   output logic          host_rd_valid_out,
   output logic [BW-1:0] bram_rd_bank_out,
   output logic [AW-1:0] bram_rd_addr_out,
   output logic          bram_rd_en_out,
   output logic [BW-1:0] bram_wr_bank_out
);

   localparam logic [BW-1:0] LAST_PASS = BW'(NUM_SCALES - 2);

   if (NUM_SCALES < 2 || BIT_DEPTH < 1) begin : g_param_check
      $error("blur_scheduler: NUM_SCALES must be >= 2 and BIT_DEPTH >= 1");
   end

   state_e        state_q, state_d;
   logic [BW-1:0] pass_q, pass_d;
   logic          wd_clr, wd_en, wd_exp;
   logic          eng_owns, host_owns, bank_ok, grant;
   logic [BRAM_RD_LATENCY:1] vld_pipe_q, vld_pipe_d;

   pass_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .clr_i     (wd_clr),
      .en_i      (wd_en),
      .expired_o (wd_exp)
   );

   // Pass sequencing: next state, pass index and watchdog control.
   always_comb begin
      state_d        = state_q;
      pass_d         = pass_q;
      wd_clr         = 1'b0;
      wd_en          = 1'b0;
      blur_start_out = 1'b0;
      done_out       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_in) begin
               state_d = LAUNCH;
               pass_d  = '0;
            end
         end
         LAUNCH: begin
            blur_start_out = 1'b1;
            wd_clr         = 1'b1;
            state_d        = WAIT;
         end
         WAIT: begin
            wd_en = 1'b1;
            // A completion in the expiry cycle still counts as success.
            if (blur_done_in) begin
               if (pass_q == LAST_PASS) begin
                  state_d = DONE;
               end else begin
                  pass_d  = pass_q + 1'b1;
                  state_d = LAUNCH;
               end
            end else if (wd_exp) begin
               state_d = ERROR;
            end
         end
         DONE: begin
            done_out = 1'b1;
            pass_d   = '0;
            state_d  = IDLE;
         end
         ERROR: begin
            if (clear_err_in) begin
               pass_d  = '0;
               state_d = IDLE;
            end
         end
         default: begin
            pass_d  = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State and pass index registers.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= IDLE;
         pass_q  <= '0;
      end else begin
         state_q <= state_d;
         pass_q  <= pass_d;
      end
   end

   assign busy_out         = (state_q != IDLE);
   assign error_out        = (state_q == ERROR);
   assign pass_idx_out     = pass_q;
   assign bram_wr_bank_out = (state_q == LAUNCH || state_q == WAIT) ? pass_q + 1'b1 : '0;

   // Host only owns the port between octaves; reset forces every output low.
   assign eng_owns  = (state_q == LAUNCH || state_q == WAIT || state_q == ERROR);
   assign host_owns = rst_in && (state_q == IDLE || state_q == DONE);
   assign bank_ok   = (32'(host_rd_bank_in) < NUM_SCALES);

   // Shared read-port mux.
   always_comb begin
      grant            = 1'b0;
      bram_rd_bank_out = '0;
      bram_rd_addr_out = '0;
      bram_rd_en_out   = 1'b0;
      if (eng_owns) begin
         bram_rd_bank_out = pass_q;
         bram_rd_addr_out = eng_rd_addr_in;
         bram_rd_en_out   = eng_rd_valid_in;
      end else if (host_owns) begin
         grant            = host_rd_req_in && bank_ok;
         bram_rd_bank_out = host_rd_bank_in;
         bram_rd_addr_out = host_rd_addr_in;
         bram_rd_en_out   = grant;
      end
   end

   assign host_rd_grant_out = grant;

   // Grants ride a shift register matching BRAM latency; in-flight reads
   // finish regardless of later state changes.
   always_comb begin
      vld_pipe_d = {vld_pipe_q[BRAM_RD_LATENCY-1:1], grant};
   end

   // Read-valid pipeline register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) vld_pipe_q <= '0;
      else         vld_pipe_q <= vld_pipe_d;
   end

   assign host_rd_valid_out = vld_pipe_q[BRAM_RD_LATENCY];

endmodule

// File: tb/tb_blur_scheduler.sv
// Scoreboard bench for blur_scheduler: an abstract octave model predicts
// engine starts, done/error pulses and host read grants/valids.
module tb_blur_scheduler;

   localparam int NS = 5;
   localparam int TO = 150;
   localparam int AW = 12;
   localparam int BW = 3;

   localparam int K_START = 0;
   localparam int K_DONE  = 1;
   localparam int K_ERR   = 2;
   localparam int K_HG    = 3;
   localparam int K_HV    = 4;

   typedef struct packed { int k; int c; int a; int b; } ev_t;
   typedef int dl_t [NS-1];

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b0;
   logic          start_in = 1'b0;
   logic          clear_err_in = 1'b0;
   logic          done_out, busy_out, error_out, blur_start_out;
   logic [BW-1:0] pass_idx_out;
   logic          eng_done = 1'b0, spur_done = 1'b0;
   logic          blur_done_in;
   logic [AW-1:0] eng_rd_addr_in = '0;
   logic          eng_rd_valid_in = 1'b0;
   logic          host_rd_req_in = 1'b0;
   logic [BW-1:0] host_rd_bank_in = '0;
   logic [AW-1:0] host_rd_addr_in = '0;
   logic          host_rd_grant_out, host_rd_valid_out, bram_rd_en_out;
   logic [BW-1:0] bram_rd_bank_out, bram_wr_bank_out;
   logic [AW-1:0] bram_rd_addr_out;

   assign blur_done_in = eng_done | spur_done;

   blur_scheduler #(.BIT_DEPTH(8), .WIDTH(64), .HEIGHT(64), .NUM_SCALES(NS), .TIMEOUT(TO)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .clear_err_in(clear_err_in),
      .done_out(done_out), .busy_out(busy_out), .error_out(error_out),
      .pass_idx_out(pass_idx_out), .blur_start_out(blur_start_out), .blur_done_in(blur_done_in),
      .eng_rd_addr_in(eng_rd_addr_in), .eng_rd_valid_in(eng_rd_valid_in),
      .host_rd_req_in(host_rd_req_in), .host_rd_bank_in(host_rd_bank_in),
      .host_rd_addr_in(host_rd_addr_in), .host_rd_grant_out(host_rd_grant_out),
      .host_rd_valid_out(host_rd_valid_out), .bram_rd_bank_out(bram_rd_bank_out),
      .bram_rd_addr_out(bram_rd_addr_out), .bram_rd_en_out(bram_rd_en_out),
      .bram_wr_bank_out(bram_wr_bank_out)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   ev_t evq[$];
   int  del_q[$];
   int  done_at = -1;
   int  n_cmp = 0;
   int  n_bad = 0;

   function automatic void chk(string nm, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic void push(int k, int c, int a, int b);
      ev_t e;
      e.k = k; e.c = c; e.a = a; e.b = b;
      evq.push_back(e);
   endfunction

   function automatic bit take(input int k, output ev_t e);
      e = '0;
      for (int i = 0; i < evq.size(); i++) begin
         if (evq[i].k == k) begin
            e = evq[i];
            evq.delete(i);
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   function automatic void unexpected(string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got event at cycle %0d expected none", nm, cyc);
   endfunction

   // Engine model: completes a pass a scripted number of cycles after its start.
   initial begin
      forever begin
         @(negedge clk_in);
         if (blur_start_out) begin
            if (del_q.size() > 0) done_at = cyc + del_q.pop_front();
            else                  done_at = cyc + 10;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk_in);
         #1;
         eng_done = (cyc == done_at);
      end
   end

   // Monitor: every DUT-presented event is matched against the scoreboard.
   initial begin
      ev_t e;
      bit  ep = 1'b0;
      forever begin
         @(negedge clk_in);
         if (blur_start_out) begin
            if (!take(K_START, e)) unexpected("start");
            else begin
               chk("start_cyc", cyc, e.c);
               chk("start_pass", int'(pass_idx_out), e.a);
               chk("start_src_bank", int'(bram_rd_bank_out), e.a);
               chk("start_dst_bank", int'(bram_wr_bank_out), e.b);
            end
         end
         if (done_out) begin
            if (!take(K_DONE, e)) unexpected("done");
            else chk("done_cyc", cyc, e.c);
         end
         if (error_out && !ep) begin
            if (!take(K_ERR, e)) unexpected("error_rise");
            else chk("error_cyc", cyc, e.c);
         end
         ep = error_out;
         if (host_rd_grant_out) begin
            if (!take(K_HG, e)) unexpected("host_grant");
            else begin
               chk("hg_cyc", cyc, e.c);
               chk("hg_bank", int'(bram_rd_bank_out), e.a);
               chk("hg_addr", int'(bram_rd_addr_out), e.b);
               chk("hg_en", int'(bram_rd_en_out), 1);
            end
         end
         if (host_rd_valid_out) begin
            if (!take(K_HV, e)) unexpected("host_valid");
            else chk("hv_cyc", cyc, e.c);
         end
      end
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic flush_engine();
      done_at = -1;
      del_q.delete();
   endtask

   task automatic host_read(input int bank, input int addr);
      host_rd_req_in  = 1'b1;
      host_rd_bank_in = BW'(bank);
      host_rd_addr_in = AW'(addr);
      if (bank < NS) begin
         push(K_HG, cyc, bank, addr);
         push(K_HV, cyc + 2, 0, 0);
      end
   endtask

   // One octave: model computes every start, then done or error timing.
   task automatic octave(input dl_t ds, input bit spur, input bit hostw);
      int t, s, s2, end_c, ea;
      bit err;
      t = cyc; s = t + 1; s2 = 0; err = 1'b0; end_c = 0;
      start_in = 1'b1;
      for (int k = 0; k < NS - 1; k++) del_q.push_back(ds[k]);
      for (int k = 0; k < NS - 1; k++) begin
         if (k == 2) s2 = s;
         push(K_START, s, k, k + 1);
         if (ds[k] >= TO) begin
            push(K_ERR, s + TO, 0, 0);
            end_c = s + TO;
            err = 1'b1;
            break;
         end
         s = s + ds[k] + 1;
      end
      if (!err) begin
         push(K_DONE, s, 0, 0);
         end_c = s;
      end
      step();
      start_in = 1'b0;
      while (cyc <= end_c + 1) begin
         start_in = spur && (cyc == s2 + 3);
         if (spur && cyc == s2 + 4) chk("spur_pass_idx", int'(pass_idx_out), 2);
         if (hostw && cyc == t + 5) begin
            ea = $urandom_range(4095, 0);
            eng_rd_addr_in  = AW'(ea);
            eng_rd_valid_in = 1'b1;
            host_rd_req_in  = 1'b1;
            host_rd_bank_in = 3'd3;
            host_rd_addr_in = 12'd10;
            #1;
            chk("wait_grant", int'(host_rd_grant_out), 0);
            chk("wait_rd_bank", int'(bram_rd_bank_out), 0);
            chk("wait_rd_addr", int'(bram_rd_addr_out), ea);
            chk("wait_rd_en", int'(bram_rd_en_out), 1);
         end
         if (cyc >= t + 1 && cyc <= end_c) chk("busy_in_octave", int'(busy_out), 1);
         step();
         host_rd_req_in  = 1'b0;
         eng_rd_valid_in = 1'b0;
      end
      start_in = 1'b0;
      chk("busy_after", int'(busy_out), err ? 1 : 0);
      if (err) flush_engine();
   endtask

   task automatic clear_error();
      clear_err_in = 1'b1;
      step();
      clear_err_in = 1'b0;
      chk("clr_error", int'(error_out), 0);
      chk("clr_busy", int'(busy_out), 0);
      chk("clr_pass", int'(pass_idx_out), 0);
      step();
   endtask

   function automatic dl_t rnd_delays();
      dl_t d;
      for (int k = 0; k < NS - 1; k++) d[k] = $urandom_range(120, 8);
      return d;
   endfunction

   task automatic check_zero_outputs(string tag);
      chk({tag, "_busy"},  int'(busy_out), 0);
      chk({tag, "_error"}, int'(error_out), 0);
      chk({tag, "_done"},  int'(done_out), 0);
      chk({tag, "_bstart"}, int'(blur_start_out), 0);
      chk({tag, "_pass"},  int'(pass_idx_out), 0);
      chk({tag, "_wrbank"}, int'(bram_wr_bank_out), 0);
      chk({tag, "_rden"},  int'(bram_rd_en_out), 0);
      chk({tag, "_grant"}, int'(host_rd_grant_out), 0);
      chk({tag, "_hvalid"}, int'(host_rd_valid_out), 0);
   endtask

   initial begin
      int r;
      // Reset state, with a host request pending that must not be granted.
      host_rd_req_in  = 1'b1;
      host_rd_bank_in = 3'd2;
      #2;
      check_zero_outputs("reset");
      host_rd_req_in = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      step();

      // Host read while idle.
      host_read(3, 10);
      step();
      host_rd_req_in = 1'b0;
      repeat (4) step();

      // Random host reads, including out-of-range banks.
      for (int i = 0; i < 24; i++) begin
         r = $urandom;
         if (r[0]) host_read($urandom_range(7, 0), $urandom_range(4095, 0));
         else host_rd_req_in = 1'b0;
         step();
      end
      host_rd_req_in = 1'b0;
      repeat (4) step();

      // Nominal octave with a host request during WAIT.
      octave('{100, 100, 100, 100}, 1'b0, 1'b1);
      repeat (3) step();

      // Random-latency octaves, one with a stray start during pass 2.
      octave(rnd_delays(), 1'b1, 1'b0);
      repeat (2) step();
      octave(rnd_delays(), 1'b0, 1'b1);
      repeat (2) step();

      // Stray engine completion while idle.
      spur_done = 1'b1;
      step();
      spur_done = 1'b0;
      repeat (3) step();
      chk("idle_spur_pass", int'(pass_idx_out), 0);
      chk("idle_spur_busy", int'(busy_out), 0);

      // Hung engine on pass 2, start ignored in ERROR, then clear and rerun.
      octave('{20, 30, 100000, 10}, 1'b0, 1'b0);
      repeat (3) step();
      chk("err_hold", int'(error_out), 1);
      chk("err_busy", int'(busy_out), 1);
      chk("err_wrbank", int'(bram_wr_bank_out), 0);
      start_in = 1'b1;
      step();
      start_in = 1'b0;
      repeat (3) step();
      chk("err_start_ignored", int'(error_out), 1);
      chk("err_pass_kept", int'(pass_idx_out), 2);
      clear_error();
      octave(rnd_delays(), 1'b0, 1'b0);
      repeat (2) step();

      // Watchdog boundary on the last pass: TO-1 completes, TO errors.
      octave('{10, 10, 10, TO - 1}, 1'b0, 1'b0);
      repeat (2) step();
      octave('{10, 10, 10, TO}, 1'b0, 1'b0);
      repeat (2) step();
      clear_error();

      // Asynchronous reset in the middle of WAIT.
      push(K_START, cyc + 1, 0, 1);
      del_q.push_back(100);
      start_in = 1'b1;
      step();
      start_in = 1'b0;
      repeat (20) step();
      #2;
      rst_in = 1'b0;
      #1;
      check_zero_outputs("midrst");
      evq.delete();
      flush_engine();
      repeat (2) @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      step();
      octave(rnd_delays(), 1'b0, 1'b0);
      repeat (5) step();

      chk("scoreboard_empty", evq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
